// File: rtl/neuron_input_streamer.sv
// Buffers one input vector, streams it to a serial-MAC neuron one word per clock, then captures the sum.
// Define PING_PONG_EN for two vector banks so the next vector can load while the current one streams.
module neuron_input_streamer #(
  parameter int NUM_INPUTS = 784,
  parameter int DATA_WIDTH = 16,
  parameter int SUM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  nrn_freeze,
  output logic [DATA_WIDTH-1:0] nrn_input,
  input  logic [SUM_WIDTH-1:0]  nrn_sum,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SUM_WIDTH-1:0]  res_data,
  output logic                  busy
);

`ifdef PING_PONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic PP       = (NB == 2);
  localparam int   AW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int   MW       = $clog2(NB * NUM_INPUTS);
  localparam int   BANK_OFS = (NB == 2) ? NUM_INPUTS : 0;
  localparam logic [AW-1:0] LAST = AW'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, CAPTURE} state_t;

  logic [DATA_WIDTH-1:0] mem [NB*NUM_INPUTS];

  state_t                state_q;
  logic [AW-1:0]         wr_addr_q;
  logic                  wr_bank_q;
  logic                  rd_bank_q;
  logic [AW-1:0]         rd_cnt_q;
  logic [1:0]            full_q, full_d;
  logic                  rdy_en_q;
  logic                  freeze_q;
  logic [DATA_WIDTH-1:0] input_q;
  logic                  res_valid_q;
  logic [SUM_WIDTH-1:0]  res_data_q;

  logic          wr_fire, wr_last;
  logic          nx_bank, rd_full_now, nx_full_now, res_free;
  logic          rd_sel_bank;
  logic [AW-1:0] rd_sel_addr;
  logic [MW-1:0] wr_idx, rd_idx;

  function automatic logic [MW-1:0] mem_idx(input logic bank, input logic [AW-1:0] addr);
    mem_idx = (bank ? MW'(BANK_OFS) : '0) + MW'(addr);
  endfunction

  assign s_ready    = rdy_en_q & ~full_q[wr_bank_q];
  assign wr_fire    = s_valid & s_ready;
  assign wr_last    = wr_fire & (wr_addr_q == LAST);
  assign nx_bank    = rd_bank_q ^ PP;
  assign res_free   = ~res_valid_q | res_ready;
  // A bank completing its final write this cycle already counts as full so the stream starts next cycle.
  assign rd_full_now = full_q[rd_bank_q] | (wr_last & (wr_bank_q == rd_bank_q));
  assign nx_full_now = PP & (full_q[nx_bank] | (wr_last & (wr_bank_q == nx_bank)));

  assign wr_idx = mem_idx(wr_bank_q, wr_addr_q);
  assign rd_idx = mem_idx(rd_sel_bank, rd_sel_addr);

  always_comb begin
    rd_sel_bank = rd_bank_q;
    rd_sel_addr = rd_cnt_q + 1'b1;
    if (state_q == IDLE) begin
      rd_sel_addr = '0;
    end else if (state_q == CAPTURE) begin
      rd_sel_bank = nx_bank;
      rd_sel_addr = '0;
    end
  end

  always_comb begin
    full_d = full_q;
    if (state_q == CAPTURE) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_idx] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      full_q   <= full_d;
      if (wr_fire) begin
        wr_addr_q <= wr_last ? '0 : wr_addr_q + 1'b1;
        if (wr_last) wr_bank_q <= wr_bank_q ^ PP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      freeze_q    <= 1'b1;
      input_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_full_now && res_free) begin
            state_q  <= STREAM;
            freeze_q <= 1'b0;
            input_q  <= mem[rd_idx];
            rd_cnt_q <= '0;
          end
        end
        STREAM: begin
          if (rd_cnt_q == LAST) begin
            state_q  <= CAPTURE;
            freeze_q <= 1'b1;
            input_q  <= '0;
          end else begin
            input_q  <= mem[rd_idx];
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          res_data_q  <= nrn_sum;
          res_valid_q <= 1'b1;
          rd_bank_q   <= nx_bank;
          // Chain straight into the other bank so only this cycle separates two streams.
          if (nx_full_now && res_ready) begin
            state_q  <= STREAM;
            freeze_q <= 1'b0;
            input_q  <= mem[rd_idx];
            rd_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          freeze_q <= 1'b1;
          input_q  <= '0;
        end
      endcase
    end
  end

  assign nrn_freeze = freeze_q;
  assign nrn_input  = input_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_input_streamer.sv
// Directed bench for neuron_input_streamer with NUM_INPUTS=4 and a behavioural saturating neuron.
module tb_neuron_input_streamer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          nrn_freeze;
  logic [DW-1:0] nrn_input;
  logic [SW-1:0] nrn_sum;
  logic          res_valid;
  logic          res_ready;
  logic [SW-1:0] res_data;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_input_streamer #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .SUM_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .nrn_freeze(nrn_freeze), .nrn_input(nrn_input), .nrn_sum(nrn_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // Neuron model: word k times weight k on the k-th freeze-low cycle, bias added on the last, saturated output.
  logic [N-1:0][DW-1:0] nrn_w;
  logic signed [SW-1:0] nrn_b;
  logic [1:0]           k_m = '0;
  longint               acc_m = 0;
  longint               prod_m;

  always_comb prod_m = longint'($signed(nrn_input)) * longint'($signed(nrn_w[k_m]));

  always @(posedge clk) begin
    if (!nrn_freeze) begin
      acc_m <= ((k_m == 2'd0) ? 64'sd0 : acc_m) + prod_m + ((k_m == 2'd3) ? longint'(nrn_b) : 64'sd0);
      k_m   <= k_m + 2'd1;
    end else begin
      k_m <= '0;
    end
  end

  always_comb begin
    if (acc_m > 64'sd2147483647)       nrn_sum = 32'h7FFFFFFF;
    else if (acc_m < -64'sd2147483648) nrn_sum = 32'h80000000;
    else                               nrn_sum = acc_m[31:0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic load_vec(input logic [N-1:0][DW-1:0] x, input bit tog, input string nm);
    int  i = 0;
    int  cyc = 0;
    logic acc;
    while (i < N && cyc < 100) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = x[i];
      acc     = s_ready;
      @(posedge clk);
      cyc++;
      if (acc) i++;
      if (tog && i < N) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 16'hDEAD;
        @(posedge clk);
        cyc++;
      end
    end
    #1 s_valid = 1'b0;
    chk({nm, " load words"}, 64'(i), 64'(N));
  endtask

  task automatic observe(input logic [N-1:0][DW-1:0] x, input logic [SW-1:0] exp,
                         input bit check_result, input string nm);
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      chk($sformatf("%s freeze_low%0d", nm, j), 64'(nrn_freeze), 64'd0);
      chk($sformatf("%s input%0d", nm, j), 64'(nrn_input), 64'(x[j]));
`ifndef PING_PONG_EN
      if (j == 0) chk({nm, " s_ready_in_stream"}, 64'(s_ready), 64'd0);
`endif
    end
    @(negedge clk);
    chk({nm, " capture_freeze"}, 64'(nrn_freeze), 64'd1);
    chk({nm, " capture_busy"}, 64'(busy), 64'd1);
    chk({nm, " capture_input"}, 64'(nrn_input), 64'd0);
    if (check_result) begin
      @(negedge clk);
      chk({nm, " res_valid"}, 64'(res_valid), 64'd1);
      chk({nm, " res_data"}, 64'(res_data), 64'(exp));
      $display("txn %s res_data=%08h expected=%08h", nm, res_data, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0][DW-1:0] x;
    logic [N-1:0][DW-1:0] w;
    logic [SW-1:0]        b;
    logic                 tog;
    logic [SW-1:0]        exp;
  } vec_t;

  localparam logic [N-1:0][DW-1:0] W1234 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [N-1:0][DW-1:0] X1234 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [N-1:0][DW-1:0] X2222 = {16'd2, 16'd2, 16'd2, 16'd2};

  vec_t vt [4];

  initial begin
    vt[0] = '{x: X1234, w: W1234, b: 32'd5, tog: 1'b0, exp: 32'h00000023};
    vt[1] = '{x: X1234, w: W1234, b: 32'd5, tog: 1'b1, exp: 32'h00000023};
    vt[2] = '{x: {16'd4, 16'hFFFD, 16'd2, 16'hFFFF}, w: W1234, b: 32'd5, tog: 1'b0, exp: 32'h0000000F};
    vt[3] = '{x: {4{16'h7FFF}}, w: {4{16'h7FFF}}, b: 32'd5, tog: 1'b0, exp: 32'h7FFFFFFF};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; res_ready = 1'b1;
    nrn_w = W1234; nrn_b = 32'sd5;
    repeat (2) @(negedge clk);
    chk("rst freeze", 64'(nrn_freeze), 64'd1);
    chk("rst input", 64'(nrn_input), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst res_data", 64'(res_data), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1 chk("s_ready before first edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("s_ready after first edge", 64'(s_ready), 64'd1);

    for (int v = 0; v < 4; v++) begin
      nrn_w = vt[v].w;
      nrn_b = vt[v].b;
      load_vec(vt[v].x, vt[v].tog, $sformatf("vec%0d", v));
      observe(vt[v].x, vt[v].exp, 1'b1, $sformatf("vec%0d", v));
    end
    nrn_w = W1234; nrn_b = 32'sd5;

    // Pending result blocks the second stream until res_ready rises.
    @(negedge clk);
    res_ready = 1'b0;
    load_vec(X1234, 1'b0, "hold_a");
    observe(X1234, 32'h23, 1'b1, "hold_a");
    load_vec(X2222, 1'b0, "hold_b");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold wait_freeze%0d", c), 64'(nrn_freeze), 64'd1);
      chk($sformatf("hold res_data%0d", c), 64'(res_data), 64'h23);
      chk($sformatf("hold res_valid%0d", c), 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    observe(X2222, 32'h19, 1'b1, "hold_b");

    // Reset in stream cycle 2 aborts the vector.
    load_vec(X1234, 1'b0, "rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid freeze", 64'(nrn_freeze), 64'd1);
    chk("rst_mid input", 64'(nrn_input), 64'd0);
    chk("rst_mid res_valid", 64'(res_valid), 64'd0);
    chk("rst_mid res_data", 64'(res_data), 64'd0);
    chk("rst_mid busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_vec(X1234, 1'b0, "after_rst");
    observe(X1234, 32'h23, 1'b1, "after_rst");

`ifdef PING_PONG_EN
    load_vec(X1234, 1'b0, "pp_a");
    fork
      load_vec(X2222, 1'b0, "pp_b");
      observe(X1234, 32'h23, 1'b0, "pp_a");
    join
    fork
      observe(X2222, 32'h19, 1'b1, "pp_b");
      begin
        @(negedge clk);
        chk("pp_a res_valid", 64'(res_valid), 64'd1);
        chk("pp_a res_data", 64'(res_data), 64'h23);
        $display("txn pp_a res_data=%08h expected=00000023", res_data);
      end
    join
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
